sram_controller: RTL and testbench

Sequences 32-bit data-memory accesses issued by the EXE/MEM boundary onto a 16-bit-wide external SRAM. Each load or store is split into two half-word phases of fixed length. The controller drives `ready` low to freeze the pipeline until the word transfer completes. It sits between the MEM stage inputs (ALU_result as address, MEM_R_EN/MEM_W_EN, Val_Rm as store data) and the SRAM pins.

---
 rtl/sram_controller_pkg.sv | 16 +
 rtl/sram_controller_access_timer.sv | 28 ++
 rtl/sram_controller.sv | 136 +++++++++++++
 tb/tb_sram_controller.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared types and defaults for the 32-bit-to-16-bit SRAM access controller.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int          SRAM_ADDR_W           = 18;
    localparam int          SRAM_DATA_W           = 16;
    localparam int          DEFAULT_ACCESS_CYCLES = 2;
    localparam logic [31:0] DEFAULT_BASE_ADDR     = 32'd1024;

endpackage

// File: rtl/sram_controller_access_timer.sv
// Phase counter: counts 0..ACCESS_CYCLES-1 within one half-word phase and flags the last cycle.
module access_timer #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_phase_last
);

    localparam int             CW   = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(ACCESS_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Saturates on the last cycle so a stalled phase cannot wrap.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_en && !o_phase_last) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_phase_last = (r_count == LAST);

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two fixed-length half-word phases on a 16-bit SRAM,
// holding ready low until the word transfer completes.
module sram_controller
    import sram_pkg::*;
#(
    parameter int          ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES,
    parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in
);

    state_t        r_state;
    state_t        w_next;
    logic          r_write;
    logic [16:0]   r_word;
    logic [31:0]   r_wdata;
    logic [31:0]   r_read_data;

    logic          w_req;
    logic          w_accept;
    logic          w_busy;
    logic          w_timer_clear;
    logic          w_phase_last;
    logic [31:0]   w_offset;
    logic          w_unused;

    assign w_req    = rd_en | wr_en;
    assign w_busy   = (r_state == LO) || (r_state == HI);
    assign w_offset = address - BASE_ADDR;
    // Only word bits that reach the 18-bit half-word address are kept.
    assign w_unused = ^{w_offset[31:19], w_offset[1:0]};

    access_timer #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_timer_clear),
        .i_en        (w_busy),
        .o_phase_last(w_phase_last)
    );

    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        w_timer_clear = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next        = LO;
                    w_accept      = 1'b1;
                    w_timer_clear = 1'b1;
                end
            end
            LO: begin
                if (w_phase_last) begin
                    w_next        = HI;
                    w_timer_clear = 1'b1;
                end
            end
            HI: begin
                if (w_phase_last) begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Write wins when both request lines are high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_write <= 1'b0;
            r_word  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write <= wr_en;
                r_word  <= w_offset[18:2];
                r_wdata <= write_data;
            end
        end
    end

    // A reset that aborts a read keeps whatever half was already captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (!w_busy) begin
                r_read_data <= '0;
            end
        end else if (!r_write && w_phase_last) begin
            if (r_state == LO) begin
                r_read_data[15:0] <= sram_dq_in;
            end else if (r_state == HI) begin
                r_read_data[31:16] <= sram_dq_in;
            end
        end
    end

    assign read_data = r_read_data;

    always_comb begin
        ready       = 1'b0;
        sram_addr   = '0;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = '0;
        case (r_state)
            IDLE: ready = ~w_req;
            DONE: ready = 1'b1;
            default: begin
                sram_addr  = {r_word, (r_state == HI)};
                sram_we_n  = ~r_write;
                sram_dq_oe = r_write;
                if (r_write) begin
                    sram_dq_out = (r_state == HI) ? r_wdata[31:16] : r_wdata[15:0];
                end
            end
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (ACCESS_CYCLES 2 and 1) against a transaction-level model.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en [2];
    logic        wr_en [2];
    logic [31:0] address [2];
    logic [31:0] write_data [2];
    logic [31:0] read_data [2];
    logic        ready [2];
    logic [17:0] sram_addr [2];
    logic        sram_we_n [2];
    logic [15:0] sram_dq_out [2];
    logic        sram_dq_oe [2];
    logic [15:0] sram_dq_in [2];

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    sram_controller #(.ACCESS_CYCLES(2), .BASE_ADDR(32'd1024)) u_dut2 (
        .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
        .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
        .ready(ready[0]), .sram_addr(sram_addr[0]), .sram_we_n(sram_we_n[0]),
        .sram_dq_out(sram_dq_out[0]), .sram_dq_oe(sram_dq_oe[0]), .sram_dq_in(sram_dq_in[0])
    );

    sram_controller #(.ACCESS_CYCLES(1), .BASE_ADDR(32'd1024)) u_dut1 (
        .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
        .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
        .ready(ready[1]), .sram_addr(sram_addr[1]), .sram_we_n(sram_we_n[1]),
        .sram_dq_out(sram_dq_out[1]), .sram_dq_oe(sram_dq_oe[1]), .sram_dq_in(sram_dq_in[1])
    );

    function automatic int ncyc(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int key(int i, logic [17:0] a);
        return i * 262144 + int'(a);
    endfunction

    function automatic logic [15:0] fill(int k);
        int t;
        t = k * 40503 + 12345;
        return t[15:0] ^ t[31:16];
    endfunction

    // External SRAM: writes on every edge with we_n low, read data settles mid-cycle.
    logic [15:0] sram_mem [int];
    logic [15:0] ref_mem [int];

    function automatic logic [15:0] sram_rd(int k);
        return sram_mem.exists(k) ? sram_mem[k] : fill(k);
    endfunction

    function automatic logic [15:0] ref_rd(int k);
        return ref_mem.exists(k) ? ref_mem[k] : fill(k);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (chk_en && !sram_we_n[i]) sram_mem[key(i, sram_addr[i])] = sram_dq_out[i];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) sram_dq_in[i] = sram_rd(key(i, sram_addr[i]));
    end

    // Model: m_k is the cycle number within an access (0 idle, 1..2N phases, 2N+1 done).
    int          m_k [2] = '{0, 0};
    logic        m_wr [2] = '{1'b0, 1'b0};
    logic [31:0] m_word [2] = '{32'd0, 32'd0};
    logic [31:0] m_wdata [2] = '{32'd0, 32'd0};
    logic [31:0] m_rd [2] = '{32'd0, 32'd0};
    int          m_n;
    logic [17:0] m_lo, m_hi;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_n  = ncyc(i);
            m_lo = {m_word[i][16:0], 1'b0};
            m_hi = {m_word[i][16:0], 1'b1};
            if (m_k[i] >= 1 && m_k[i] <= 2 * m_n && m_wr[i]) begin
                if (m_k[i] <= m_n) ref_mem[key(i, m_lo)] = m_wdata[i][15:0];
                else               ref_mem[key(i, m_hi)] = m_wdata[i][31:16];
            end
            if (rst) begin
                if (m_k[i] == 0 || m_k[i] == 2 * m_n + 1) m_rd[i] = 32'd0;
                m_k[i]  = 0;
                m_wr[i] = 1'b0;
            end else if (m_k[i] == 0) begin
                if (rd_en[i] || wr_en[i]) begin
                    m_k[i]     = 1;
                    m_wr[i]    = wr_en[i];
                    m_word[i]  = (address[i] - 32'd1024) >> 2;
                    m_wdata[i] = write_data[i];
                end
            end else if (m_k[i] <= 2 * m_n) begin
                if (!m_wr[i] && m_k[i] == m_n)     m_rd[i][15:0]  = ref_rd(key(i, m_lo));
                if (!m_wr[i] && m_k[i] == 2 * m_n) m_rd[i][31:16] = ref_rd(key(i, m_hi));
                m_k[i] = m_k[i] + 1;
            end else begin
                m_k[i] = 0;
            end
        end
    end

    task automatic check(string name, int inst, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] act=%h exp=%h at %0t", name, inst, act, exp, $time);
        end
    endtask

    int          c_n;
    logic        c_busy, c_hi, c_rdy;
    logic [17:0] c_addr;
    logic [15:0] c_dq;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                c_n    = ncyc(i);
                c_busy = (m_k[i] >= 1 && m_k[i] <= 2 * c_n);
                c_hi   = (m_k[i] > c_n);
                c_rdy  = (m_k[i] == 0) ? !(rd_en[i] || wr_en[i]) : (m_k[i] == 2 * c_n + 1);
                c_addr = c_busy ? {m_word[i][16:0], c_hi} : 18'd0;
                c_dq   = (c_busy && m_wr[i]) ? (c_hi ? m_wdata[i][31:16] : m_wdata[i][15:0]) : 16'd0;
                check("ready", i, 32'(ready[i]), 32'(c_rdy));
                check("sram_addr", i, 32'(sram_addr[i]), 32'(c_addr));
                check("sram_we_n", i, 32'(sram_we_n[i]), 32'(!(c_busy && m_wr[i])));
                check("sram_dq_oe", i, 32'(sram_dq_oe[i]), 32'(c_busy && m_wr[i]));
                check("sram_dq_out", i, 32'(sram_dq_out[i]), 32'(c_dq));
                check("read_data", i, read_data[i], m_rd[i]);
            end
        end
    end

    logic        cap_rdy [16];
    logic [17:0] cap_addr [16];
    logic        cap_we [16];
    logic        cap_oe [16];
    logic [31:0] cap_rd [16];

    task automatic capture(int i, int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            cap_rdy[c]  = ready[i];
            cap_addr[c] = sram_addr[i];
            cap_we[c]   = sram_we_n[i];
            cap_oe[c]   = sram_dq_oe[i];
            cap_rd[c]   = read_data[i];
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(int i);
        int c;
        c = 0;
        do begin
            next_cycle();
            c++;
        end while (!ready[i] && c < 100);
        checks++;
        if (!ready[i]) begin
            errors++;
            $display("FAIL wait_done[%0d] act=timeout exp=ready", i);
        end
    endtask

    task automatic set_req(int i, logic rd, logic wr, logic [31:0] a, logic [31:0] d);
        rd_en[i]      = rd;
        wr_en[i]      = wr;
        address[i]    = a;
        write_data[i] = d;
    endtask

    task automatic rand_phase(int i, int count);
        logic [31:0] a;
        int op;
        for (int t = 0; t < count; t++) begin
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 7) == 0) ? $urandom :
                 32'd1024 + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
            next_cycle();
            set_req(i, op < 5 || op == 9, op >= 5, a, $urandom);
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 2 * ncyc(i))) next_cycle();
                rst = 1'b1;
                set_req(i, 1'b0, 1'b0, 32'd0, 32'd0);
                next_cycle();
                rst = 1'b0;
            end else begin
                wait_done(i);
                set_req(i, 1'b0, 1'b0, 32'd0, 32'd0);
                repeat ($urandom_range(0, 2)) next_cycle();
            end
        end
    endtask

    logic [6:0] pat;

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            set_req(i, 1'b0, 1'b0, 32'd0, 32'd0);
            sram_dq_in[i] = 16'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", i, 32'(ready[i]), 32'd1);
            check("rst_addr", i, 32'(sram_addr[i]), 32'd0);
            check("rst_we_n", i, 32'(sram_we_n[i]), 32'd1);
            check("rst_oe", i, 32'(sram_dq_oe[i]), 32'd0);
            check("rst_rdata", i, read_data[i], 32'd0);
        end

        // Store 0xDEADBEEF at 1024, request held into the following idle cycle
        next_cycle();
        set_req(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        capture(0, 7);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        wait_done(0);
        for (int c = 0; c < 7; c++) pat[c] = cap_rdy[c];
        check("stall_pattern", 0, 32'(pat), 32'h20);
        check("wr_addr_lo", 0, 32'(cap_addr[1]), 32'd0);
        check("wr_addr_hi", 0, 32'(cap_addr[3]), 32'd1);
        check("wr_we_n", 0, 32'({cap_we[0], cap_we[1], cap_we[2], cap_we[3], cap_we[4], cap_we[5]}), 32'b100001);
        check("mem_hw0", 0, 32'(sram_rd(key(0, 18'd0))), 32'h0000BEEF);
        check("mem_hw1", 0, 32'(sram_rd(key(0, 18'd1))), 32'h0000DEAD);

        // Load 1024
        next_cycle();
        next_cycle();
        set_req(0, 1'b1, 1'b0, 32'd1024, 32'd0);
        capture(0, 6);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("rd_ready_c4", 0, 32'(cap_rdy[4]), 32'd0);
        check("rd_ready_c5", 0, 32'(cap_rdy[5]), 32'd1);
        check("rd_half", 0, cap_rd[3], 32'h0000BEEF);
        check("rd_word", 0, cap_rd[5], 32'hDEADBEEF);
        check("rd_oe", 0, 32'({cap_oe[1], cap_we[1]}), 32'b01);

        // Simultaneous rd_en/wr_en behaves as a store
        next_cycle();
        set_req(0, 1'b1, 1'b1, 32'd1040, 32'h11112222);
        capture(0, 6);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("both_we_n", 0, 32'({cap_we[1], cap_we[2], cap_we[3], cap_we[4], cap_we[5]}), 32'b00001);
        check("both_rdata", 0, cap_rd[5], 32'hDEADBEEF);

        // Address mapping
        next_cycle();
        set_req(0, 1'b0, 1'b1, 32'd1032, $urandom);
        capture(0, 6);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("map1032_lo", 0, 32'(cap_addr[1]), 32'd4);
        check("map1032_hi", 0, 32'(cap_addr[3]), 32'd5);
        next_cycle();
        set_req(0, 1'b1, 1'b0, 32'd1000, 32'd0);
        capture(0, 6);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("map1000_lo", 0, 32'(cap_addr[2]), 32'h3FFF4);
        check("map1000_hi", 0, 32'(cap_addr[4]), 32'h3FFF5);

        // Reset in cycle 3 of a read of 1040 (holds 0x11112222)
        next_cycle();
        set_req(0, 1'b1, 1'b0, 32'd1024, 32'd0);
        wait_done(0);
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        next_cycle();
        set_req(0, 1'b1, 1'b0, 32'd1040, 32'd0);
        repeat (3) next_cycle();
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        next_cycle();
        rst = 1'b0;
        check("abort_ready", 0, 32'(ready[0]), 32'd1);
        check("abort_addr", 0, 32'(sram_addr[0]), 32'd0);
        check("abort_we_n", 0, 32'(sram_we_n[0]), 32'd1);
        check("abort_rdata", 0, read_data[0], 32'hDEAD2222);

        // ACCESS_CYCLES = 1
        next_cycle();
        set_req(1, 1'b0, 1'b1, 32'd1032, 32'hCAFEF00D);
        capture(1, 4);
        next_cycle();
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        check("n1_wr_ready", 1, 32'({cap_rdy[0], cap_rdy[1], cap_rdy[2], cap_rdy[3]}), 32'b0001);
        check("n1_addr", 1, 32'({cap_addr[1], cap_addr[2]}), {14'd0, 18'd4, 18'd5} >> 0);
        next_cycle();
        set_req(1, 1'b1, 1'b0, 32'd1032, 32'd0);
        capture(1, 4);
        next_cycle();
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        check("n1_rd_ready", 1, 32'(cap_rdy[3]), 32'd1);
        check("n1_rd_half", 1, cap_rd[2], 32'h0000F00D);
        check("n1_rd_word", 1, cap_rd[3], 32'hCAFEF00D);

        rand_phase(0, 60);
        rand_phase(1, 60);

        repeat (3) next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
